// File: rtl/cpu_msg_broadcaster_pkg.sv
// cpu_msg_broadcaster_pkg
//   Shared constants for the inter-CPU index broadcast path:
//   message codes, CPU state codes that trigger broadcasts, the
//   CPU_ACTIVE flag value, the broadcaster FSM encoding and a
//   saturating counter helper.
package cpu_msg_broadcaster_pkg;

  // Inter-CPU message codes
  localparam logic [3:0] CPU_MSG_NOP = 4'h0;
  localparam logic [3:0] CPU_R_START = 4'h1;
  localparam logic [3:0] CPU_R_END   = 4'h2;

  // Local CPU state codes that generate broadcasts
  localparam logic [7:0] START_BEGIN = 8'h10;
  localparam logic [7:0] FINISH_END  = 8'h20;

  // Value of the index MSB when the CPU is active
  localparam logic CPU_ACTIVE = 1'b1;

  typedef enum logic [1:0] {
    BCAST_IDLE,
    BCAST_REQ,
    BCAST_DRIVE,
    BCAST_BACKOFF
  } bcast_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cpu_msg_broadcaster_if.sv
// cpu_msg_broadcaster_if
//   Shared message-bus signals between one CPU's broadcaster and the
//   bus/arbiter side.
//   bus_busy_in   : bus occupied by any CPU
//   bus_grant     : arbiter grant to this CPU
//   bus_req       : request to arbiter
//   bus_busy_out  : this CPU owns the bus
//   next_cpu_q    : broadcast-valid strobe
//   cpu_msg_out   : broadcast message
//   cpu_index_out : broadcast index
interface cpu_msg_broadcaster_if #(
  parameter int DATA_W = 32,
  parameter int MSG_W  = 4
);
  logic              bus_busy_in;
  logic              bus_grant;
  logic              bus_req;
  logic              bus_busy_out;
  logic              next_cpu_q;
  logic [MSG_W-1:0]  cpu_msg_out;
  logic [DATA_W-1:0] cpu_index_out;

  modport master (
    input  bus_busy_in, bus_grant,
    output bus_req, bus_busy_out, next_cpu_q, cpu_msg_out, cpu_index_out
  );

  modport slave (
    output bus_busy_in, bus_grant,
    input  bus_req, bus_busy_out, next_cpu_q, cpu_msg_out, cpu_index_out
  );
endinterface

// File: rtl/cpu_msg_fifo2.sv
// cpu_msg_fifo2
//   Two-entry synchronous FIFO, advanced only on edges with en=1.
//   A push into a full FIFO is accepted when a pop happens on the same
//   edge; otherwise it is ignored (caller detects the drop).
//   clk, rst : clock, synchronous active-high reset (flushes)
//   en       : edge enable (drive phase)
//   push/din : write request and data
//   pop      : read request (head advances)
//   dout     : head entry
//   count    : occupancy 0..2; full, empty : occupancy flags
module cpu_msg_fifo2 #(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);
  assign count = cnt;
  assign dout  = mem[rd_ptr];

  always_comb begin
    do_pop  = en && pop && !empty;
    do_push = en && push && (!full || do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset; the pointers define validity. When full with
  // a coincident pop, wr_ptr equals rd_ptr, so the new entry lands in the
  // slot being vacated and becomes the tail.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cpu_msg_broadcaster.sv
// cpu_msg_broadcaster
//   Transmit side of the inter-CPU index protocol. Detects entry into
//   START_BEGIN / FINISH_END, queues an index snapshot per event, wins the
//   shared message bus and broadcasts CPU_R_START / CPU_R_END for one clock
//   period (one drive + one sample phase).
//   clk, rst      : clock, synchronous active-high reset
//   clk_oe        : 1 = drive phase (all updates), 0 = sample phase
//   state         : local CPU state
//   cpu_index     : current local index
//   bus           : message bus (master modport)
//   pending       : queued message count
//   err_overflow  : sticky, an event was dropped
//   retry_cnt     : saturating count of backoffs
module cpu_msg_broadcaster #(
  parameter int DATA_W    = 32,
  parameter int MSG_W     = 4,
  parameter int STATE_W   = 8,
  parameter int RETRY_MAX = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_oe,
  input  logic [STATE_W-1:0] state,
  input  logic [DATA_W-1:0]  cpu_index,
  cpu_msg_broadcaster_if.master bus,
  output logic [1:0]         pending,
  output logic               err_overflow,
  output logic [7:0]         retry_cnt
);
  import cpu_msg_broadcaster_pkg::*;

  localparam int ENTRY_W = MSG_W + DATA_W;
  localparam int WAIT_W  = (RETRY_MAX > 1) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(RETRY_MAX);
  localparam logic [DATA_W-1:0] ACTIVE_MASK = {CPU_ACTIVE, {(DATA_W-1){1'b0}}};

  logic [STATE_W-1:0] state_q;
  logic               start_ev;
  logic               end_ev;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head;
  logic [1:0]         fifo_count;
  logic               fifo_full;
  logic               fifo_empty;

  bcast_state_t       fsm_q, fsm_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               req_q, req_d;
  logic               busy_q, busy_d;
  logic               ncq_q, ncq_d;
  logic [MSG_W-1:0]   msg_q, msg_d;
  logic [DATA_W-1:0]  idx_q, idx_d;
  logic               err_q, err_d;
  logic [7:0]         retry_q, retry_d;

  // Event detect and snapshot of the index at the event edge
  always_comb begin
    start_ev  = (state == STATE_W'(START_BEGIN)) && (state_q != STATE_W'(START_BEGIN));
    end_ev    = (state == STATE_W'(FINISH_END))  && (state_q != STATE_W'(FINISH_END));
    push      = start_ev || end_ev;
    push_data = start_ev ? {MSG_W'(CPU_R_START), cpu_index & ~ACTIVE_MASK}
                         : {MSG_W'(CPU_R_END),   cpu_index |  ACTIVE_MASK};
    pop       = (fsm_q == BCAST_DRIVE) && !fifo_empty;
  end

  cpu_msg_fifo2 #(.W(ENTRY_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .en    (clk_oe),
    .push  (push),
    .pop   (pop),
    .din   (push_data),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    fsm_d   = fsm_q;
    wait_d  = wait_q;
    req_d   = req_q;
    busy_d  = busy_q;
    ncq_d   = ncq_q;
    msg_d   = msg_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    err_d   = err_q | (push && fifo_full && !pop);

    case (fsm_q)
      BCAST_IDLE: begin
        if ((fifo_count != 2'd0) && !bus.bus_busy_in) begin
          fsm_d  = BCAST_REQ;
          req_d  = 1'b1;
          wait_d = '0;
        end
      end
      BCAST_REQ: begin
        if (bus.bus_grant && !bus.bus_busy_in) begin
          fsm_d  = BCAST_DRIVE;
          msg_d  = head[ENTRY_W-1 -: MSG_W];
          idx_d  = head[DATA_W-1:0];
          ncq_d  = 1'b1;
          busy_d = 1'b1;
          req_d  = 1'b1;
        end else if (wait_q == WAIT_LAST) begin
          fsm_d   = BCAST_BACKOFF;
          req_d   = 1'b0;
          retry_d = sat_inc8(retry_q);
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      BCAST_DRIVE: begin
        // Completes regardless of grant; always returns through IDLE
        fsm_d  = BCAST_IDLE;
        ncq_d  = 1'b0;
        busy_d = 1'b0;
        req_d  = 1'b0;
        msg_d  = MSG_W'(CPU_MSG_NOP);
        idx_d  = '0;
      end
      BCAST_BACKOFF: begin
        fsm_d  = BCAST_REQ;
        req_d  = 1'b1;
        wait_d = '0;
      end
      default: fsm_d = BCAST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= BCAST_IDLE;
      state_q <= '0;
      wait_q  <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      ncq_q   <= 1'b0;
      msg_q   <= MSG_W'(CPU_MSG_NOP);
      idx_q   <= '0;
      err_q   <= 1'b0;
      retry_q <= '0;
    end else if (clk_oe) begin
      fsm_q   <= fsm_d;
      state_q <= state;
      wait_q  <= wait_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      ncq_q   <= ncq_d;
      msg_q   <= msg_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      retry_q <= retry_d;
    end
  end

  assign bus.bus_req       = req_q;
  assign bus.bus_busy_out  = busy_q;
  assign bus.next_cpu_q    = ncq_q;
  assign bus.cpu_msg_out   = msg_q;
  assign bus.cpu_index_out = idx_q;
  assign pending           = fifo_count;
  assign err_overflow      = err_q;
  assign retry_cnt         = retry_q;

endmodule

// File: tb/tb_cpu_msg_broadcaster.sv
// tb_cpu_msg_broadcaster
//   Directed bench for cpu_msg_broadcaster with a broadcast scoreboard.
module tb_cpu_msg_broadcaster;
  import cpu_msg_broadcaster_pkg::*;

  localparam logic [7:0] RUN = 8'h05;

  logic        clk;
  logic        rst;
  logic        clk_oe;
  logic [7:0]  state;
  logic [31:0] cpu_index;
  logic [1:0]  pending;
  logic        err_overflow;
  logic [7:0]  retry_cnt;

  cpu_msg_broadcaster_if #(.DATA_W(32), .MSG_W(4)) bus_if ();

  cpu_msg_broadcaster #(
    .DATA_W(32), .MSG_W(4), .STATE_W(8), .RETRY_MAX(15)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_oe       (clk_oe),
    .state        (state),
    .cpu_index    (cpu_index),
    .bus          (bus_if),
    .pending      (pending),
    .err_overflow (err_overflow),
    .retry_cnt    (retry_cnt)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned bcast_cnt = 0;
  logic [35:0] sb [$];
  logic        ncq_prev = 1'b0;

  // clk_oe alternates every posedge: drive edge, then sample edge
  initial begin
    clk = 1'b0;
    clk_oe = 1'b0;
    forever begin
      #5 clk = 1'b1;
      #5 clk = 1'b0;
      clk_oe = ~clk_oe;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next drive-phase posedge
  task automatic drv();
    do @(posedge clk); while (!clk_oe);
    #1;
  endtask

  // Present an event state and index, optionally record the expected broadcast,
  // and pass the event edge
  task automatic fire(input logic [7:0] st, input logic [31:0] idx,
                      input logic [3:0] exp_msg, input logic [31:0] exp_idx,
                      input bit record, input bit hold);
    state = st;
    cpu_index = idx;
    if (record) sb.push_back({exp_msg, exp_idx});
    drv();
    if (!hold) state = RUN;
  endtask

  task automatic wait_bcast(input int unsigned max_edges, input string tag);
    bit seen = 1'b0;
    for (int unsigned i = 0; i < max_edges && !seen; i++) begin
      drv();
      seen = bus_if.next_cpu_q;
    end
    check(tag, {63'd0, seen}, 64'd1);
  endtask

  // Scoreboard: each rising broadcast strobe consumes one expected entry
  always @(negedge clk) begin
    if (bus_if.next_cpu_q && !ncq_prev) begin
      logic [35:0] e;
      bcast_cnt++;
      tests++;
      assert (sb.size() > 0) else begin
        fails++;
        $error("FAIL sb_unexpected: observed msg 0x%0h idx 0x%0h expected no broadcast",
               bus_if.cpu_msg_out, bus_if.cpu_index_out);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_msg", {60'd0, bus_if.cpu_msg_out}, {60'd0, e[35:32]});
        check("sb_idx", {32'd0, bus_if.cpu_index_out}, {32'd0, e[31:0]});
        check("sb_busy", {63'd0, bus_if.bus_busy_out}, 64'd1);
      end
    end
    ncq_prev = bus_if.next_cpu_q;
  end

  initial begin
    rst = 1'b1;
    state = RUN;
    cpu_index = '0;
    bus_if.bus_busy_in = 1'b0;
    bus_if.bus_grant = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_ncq", {63'd0, bus_if.next_cpu_q}, 64'd0);
    check("rst_req", {63'd0, bus_if.bus_req}, 64'd0);
    check("rst_msg", {60'd0, bus_if.cpu_msg_out}, 64'd0);
    check("rst_idx", {32'd0, bus_if.cpu_index_out}, 64'd0);
    check("rst_pending", {62'd0, pending}, 64'd0);
    check("rst_err_retry", {55'd0, err_overflow, retry_cnt}, 64'd0);
    rst = 1'b0;
    drv();

    // Basic START broadcast, exact latency, state held for 10 drive edges
    bus_if.bus_grant = 1'b1;
    fire(START_BEGIN, 32'h0000_0005, CPU_R_START, 32'h0000_0005, 1'b1, 1'b1);
    check("t1_pending_E", {62'd0, pending}, 64'd1);
    drv();
    check("t1_req_E1", {62'd0, bus_if.bus_req, bus_if.next_cpu_q}, 64'b10);
    drv();
    check("t1_ncq_E2", {63'd0, bus_if.next_cpu_q}, 64'd1);
    check("t1_msg_E2", {60'd0, bus_if.cpu_msg_out}, {60'd0, CPU_R_START});
    check("t1_idx_E2", {32'd0, bus_if.cpu_index_out}, 64'h5);
    @(posedge clk); #1;
    check("t1_hold_sample", {63'd0, bus_if.next_cpu_q}, 64'd1);
    drv();
    check("t1_end_ncq_req", {62'd0, bus_if.next_cpu_q, bus_if.bus_req}, 64'd0);
    check("t1_end_msg_idx", {28'd0, bus_if.cpu_msg_out, bus_if.cpu_index_out}, 64'd0);
    check("t1_end_pending", {62'd0, pending}, 64'd0);
    repeat (6) drv();
    check("t6_one_msg", {32'd0, bcast_cnt}, 64'd1);
    check("t6_pending", {62'd0, pending}, 64'd0);
    state = RUN;
    drv();

    // END broadcasts set the ACTIVE bit; START clears it
    fire(FINISH_END, 32'h8000_0003, CPU_R_END, 32'h8000_0003, 1'b1, 1'b0);
    wait_bcast(6, "t2_end_a");
    repeat (2) drv();
    fire(FINISH_END, 32'h0000_0007, CPU_R_END, 32'h8000_0007, 1'b1, 1'b0);
    wait_bcast(6, "t2_end_b");
    repeat (2) drv();
    fire(START_BEGIN, 32'hFFFF_FFFF, CPU_R_START, 32'h7FFF_FFFF, 1'b1, 1'b0);
    wait_bcast(6, "t2_start_max");
    repeat (2) drv();

    // Grant withheld: backoff after 16 waiting edges; snapshot survives index change
    bus_if.bus_grant = 1'b0;
    fire(START_BEGIN, 32'h0000_0011, CPU_R_START, 32'h0000_0011, 1'b1, 1'b0);
    cpu_index = 32'h0000_0022;
    for (int k = 1; k <= 19; k++) begin
      drv();
      check($sformatf("t3_req_E%0d", k), {62'd0, bus_if.bus_req, bus_if.next_cpu_q},
            (k == 17) ? 64'b00 : 64'b10);
      if (k == 17) check("t3_retry", {56'd0, retry_cnt}, 64'd1);
    end
    bus_if.bus_grant = 1'b1;
    wait_bcast(3, "t3_delivered");
    check("t3_retry_after", {56'd0, retry_cnt}, 64'd1);
    repeat (2) drv();

    // Bus busy: fill, overflow, then push coinciding with pop
    bus_if.bus_busy_in = 1'b1;
    fire(START_BEGIN, 32'h0000_0031, CPU_R_START, 32'h0000_0031, 1'b1, 1'b0);
    fire(FINISH_END, 32'h0000_0032, CPU_R_END, 32'h8000_0032, 1'b1, 1'b0);
    check("t4_full", {62'd0, pending}, 64'd2);
    check("t4_no_err_yet", {63'd0, err_overflow}, 64'd0);
    fire(START_BEGIN, 32'h0000_0033, CPU_R_START, 32'h0000_0033, 1'b0, 1'b0);
    check("t4_err", {63'd0, err_overflow}, 64'd1);
    check("t4_still_full", {62'd0, pending}, 64'd2);
    drv();
    bus_if.bus_busy_in = 1'b0;
    wait_bcast(6, "t4_first");
    fire(START_BEGIN, 32'h0000_0034, CPU_R_START, 32'h0000_0034, 1'b1, 1'b0);
    check("t4_push_pop", {62'd0, pending}, 64'd2);
    check("t4_gap", {63'd0, bus_if.next_cpu_q}, 64'd0);
    wait_bcast(6, "t4_second");
    drv();
    wait_bcast(6, "t4_third");
    repeat (2) drv();
    check("t4_drained", {62'd0, pending}, 64'd0);

    // Reset during DRIVE aborts the broadcast and clears everything
    fire(START_BEGIN, 32'h0000_0041, CPU_R_START, 32'h0000_0041, 1'b1, 1'b0);
    wait_bcast(6, "t5_drive");
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_ncq_busy_req", {61'd0, bus_if.next_cpu_q, bus_if.bus_busy_out, bus_if.bus_req}, 64'd0);
    check("t5_msg_idx", {28'd0, bus_if.cpu_msg_out, bus_if.cpu_index_out}, 64'd0);
    check("t5_pending_err_retry", {53'd0, pending, err_overflow, retry_cnt}, 64'd0);
    rst = 1'b0;
    repeat (4) drv();

    check("final_sb_empty", {32'd0, sb.size()}, 64'd0);
    check("final_bcast_cnt", {32'd0, bcast_cnt}, 64'd9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
